// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS control path: ALU function codes,
// opcode and operand-B select encodings, and sequencer states.
// No logic, so no latency or backpressure.
package picomips_pkg;

  localparam logic [1:0] RA   = 2'b00;
  localparam logic [1:0] RB   = 2'b01;
  localparam logic [1:0] RADD = 2'b10;
  localparam logic [1:0] RMUL = 2'b11;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_MUL  = 3'b011,
    OP_MULI = 3'b100,
    OP_MOV  = 3'b101,
    OP_IN   = 3'b110,
    OP_BZ   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    BSEL_REG = 2'd0,
    BSEL_IMM = 2'd1,
    BSEL_SW  = 2'd2
  } bsel_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WAIT_PRESS,
    WAIT_REL
  } state_t;

endpackage

// File: rtl/prog_seq_pc_reg.sv
// Program counter: synchronous reset, branch load has priority over increment.
// Latency: new value visible one cycle after inc/ld is sampled.
// Backpressure: none; holds its value whenever inc and ld are both low.
module pc_reg #(
  parameter int Psize = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             ld,
  input  logic [Psize-1:0] ld_val,
  output logic [Psize-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (ld)
      pc <= ld_val;
    else if (inc)
      pc <= pc + Psize'(1);
  end

endmodule

// File: rtl/prog_seq.sv
// picoMIPS decoder/sequencer: fetch, decode, branch, switch-input handshake.
// Latency: 2 cycles per instruction, IN takes 4+ cycles (waits on press and release).
// Backpressure: IN stalls the PC until sw_valid rises and falls; PICOMIPS_MUL_EN enables MUL/MULI.
module prog_seq
  import picomips_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Isize = 16,
  parameter int n     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Isize-1:0] instr,
  input  logic             zero,
  input  logic             sw_valid,
  output logic [Psize-1:0] pc,
  output logic [1:0]       alu_func,
  output logic [1:0]       b_sel,
  output logic [n-1:0]     imm,
  output logic [2:0]       rd_addr,
  output logic [2:0]       rs_addr,
  output logic             reg_we,
  output logic             in_wait
);

  state_t           state, state_nxt;
  op_t              op;
  logic [1:0]       dec_func;
  bsel_t            dec_bsel;
  logic             dec_wr;
  logic             pc_inc, pc_ld;
  logic [Psize-1:0] br_off, br_tgt;

  assign op     = op_t'(instr[Isize-1:Isize-3]);
  // Size cast sign-extends or truncates the immediate to the PC width.
  assign br_off = Psize'($signed(imm));
  assign br_tgt = pc + br_off;

  pc_reg #(.Psize(Psize)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_inc),
    .ld     (pc_ld),
    .ld_val (br_tgt),
    .pc     (pc)
  );

  always_comb begin
    dec_func = RA;
    dec_bsel = BSEL_REG;
    dec_wr   = 1'b0;
    case (op)
      OP_ADD:  begin dec_func = RADD; dec_bsel = BSEL_REG; dec_wr = 1'b1; end
      OP_ADDI: begin dec_func = RADD; dec_bsel = BSEL_IMM; dec_wr = 1'b1; end
`ifdef PICOMIPS_MUL_EN
      OP_MUL:  begin dec_func = RMUL; dec_bsel = BSEL_REG; dec_wr = 1'b1; end
      OP_MULI: begin dec_func = RMUL; dec_bsel = BSEL_IMM; dec_wr = 1'b1; end
`endif
      OP_MOV:  begin dec_func = RB;   dec_bsel = BSEL_REG; dec_wr = 1'b1; end
      // IN writes from the handshake states, never from EXEC.
      OP_IN:   begin dec_func = RB;   dec_bsel = BSEL_SW;  dec_wr = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    reg_we    = 1'b0;
    in_wait   = 1'b0;
    alu_func  = RA;
    b_sel     = BSEL_REG;
    imm       = '0;
    rd_addr   = '0;
    rs_addr   = '0;

    // Decode fields track the ROM word from EXEC onward; FETCH shows idle values.
    if (state != FETCH) begin
      alu_func = dec_func;
      b_sel    = dec_bsel;
      imm      = instr[n-1:0];
      rd_addr  = instr[12:10];
      rs_addr  = instr[9:7];
    end

    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        if (op == OP_IN) begin
          state_nxt = WAIT_PRESS;
        end else begin
          reg_we    = dec_wr;
          pc_ld     = (op == OP_BZ) && zero;
          pc_inc    = !pc_ld;
          state_nxt = FETCH;
        end
      end
      WAIT_PRESS: begin
        in_wait = 1'b1;
        if (sw_valid) begin
          reg_we    = 1'b1;
          state_nxt = WAIT_REL;
        end
      end
      WAIT_REL: begin
        in_wait = 1'b1;
        if (!sw_valid) begin
          pc_inc    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase

    if (reset)
      reg_we = 1'b0;
  end

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: synchronous ROM model, write scoreboard and directed programs.
module tb_prog_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0;
  logic        zero = 1'b0;
  logic        sw_valid = 1'b0;
  logic [5:0]  pc;
  logic [1:0]  alu_func;
  logic [1:0]  b_sel;
  logic [7:0]  imm;
  logic [2:0]  rd_addr;
  logic [2:0]  rs_addr;
  logic        reg_we;
  logic        in_wait;

  logic [15:0] rom [0:63];

  typedef struct {
    int alu;
    int bsel;
    int rd;
    int rs;
    int imm;
    int pc;
  } wr_t;

  wr_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  prog_seq dut (
    .clk      (clk),
    .reset    (reset),
    .instr    (instr),
    .zero     (zero),
    .sw_valid (sw_valid),
    .pc       (pc),
    .alu_func (alu_func),
    .b_sel    (b_sel),
    .imm      (imm),
    .rd_addr  (rd_addr),
    .rs_addr  (rs_addr),
    .reg_we   (reg_we),
    .in_wait  (in_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (reg_we === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write at pc %0d expected none", pc);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        chk("wr_alu_func", int'(alu_func), e.alu);
        chk("wr_b_sel",    int'(b_sel),    e.bsel);
        chk("wr_rd",       int'(rd_addr),  e.rd);
        chk("wr_rs",       int'(rs_addr),  e.rs);
        chk("wr_imm",      int'(imm),      e.imm);
        chk("wr_pc",       int'(pc),       e.pc);
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  task automatic push_wr(input int a, input int b, input int d, input int s, input int i, input int p);
    wr_t e;
    e.alu = a; e.bsel = b; e.rd = d; e.rs = s; e.imm = i; e.pc = p;
    sbq.push_back(e);
  endtask

  // Hold reset across one edge and verify the idle output state.
  task automatic start();
    reset = 1'b1;
    sw_valid = 1'b0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pc",       int'(pc),       0);
    chk("rst_reg_we",   int'(reg_we),   0);
    chk("rst_alu_func", int'(alu_func), 0);
    chk("rst_b_sel",    int'(b_sel),    0);
    chk("rst_rd",       int'(rd_addr),  0);
    chk("rst_rs",       int'(rs_addr),  0);
    chk("rst_imm",      int'(imm),      0);
    chk("rst_in_wait",  int'(in_wait),  0);
  endtask

  // Advance one cycle: drive inputs just after the edge, return at the falling edge.
  task automatic cyc(input logic s, input logic z, input logic r);
    @(posedge clk);
    #1;
    reset = r;
    sw_valid = s;
    zero = z;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int epc;

    // Program 1: ADDI, ADD, IN handshake, NOP, BZ not taken.
    clear_rom();
    rom[0] = 16'h4405;
    rom[1] = 16'h2880;
    rom[2] = 16'hCC00;
    rom[3] = 16'h0000;
    rom[4] = 16'hE0FE;
    push_wr(2, 1, 1, 0, 8'h05, 0);
    push_wr(2, 0, 2, 1, 8'h80, 1);
    push_wr(1, 2, 3, 0, 8'h00, 2);
    start();
    for (int k = 1; k <= 20; k++) begin
      cyc((k >= 12 && k <= 14) || k == 3 || k == 4, k == 18, 1'b0);
      epc = (k <= 2) ? 0 : (k <= 4) ? 1 : (k <= 15) ? 2 : (k <= 17) ? 3 : (k <= 19) ? 4 : 5;
      chk($sformatf("p1_pc_k%0d", k), int'(pc), epc);
      chk($sformatf("p1_in_wait_k%0d", k), int'(in_wait), (k >= 7 && k <= 15) ? 1 : 0);
      if (k == 19) begin
        chk("p1_bz_alu_func", int'(alu_func), 0);
        chk("p1_bz_imm", int'(imm), 8'hFE);
      end
    end
    chk("p1_sb_drain", sbq.size(), 0);

    // Program 2: BZ r0,-2 at pc 4 taken.
    clear_rom();
    rom[4] = 16'hE0FE;
    start();
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b0, k == 10, 1'b0);
      if (k == 10) chk("p2_bz_pc", int'(pc), 4);
      if (k == 11) chk("p2_bz_taken_pc", int'(pc), 2);
    end

    // Program 3: BZ -1 at pc 0 wraps to 63, then increment wraps to 0.
    clear_rom();
    rom[0] = 16'hE0FF;
    start();
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, k == 2, 1'b0);
      if (k == 3) chk("p3_wrap_back_pc", int'(pc), 63);
      if (k == 5) chk("p3_wrap_fwd_pc", int'(pc), 0);
    end

    // Program 4: MULI r1,0x40 with or without the multiplier.
    clear_rom();
    rom[0] = 16'h8440;
`ifdef PICOMIPS_MUL_EN
    push_wr(3, 1, 1, 0, 8'h40, 0);
`endif
    start();
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
`ifdef PICOMIPS_MUL_EN
      if (k == 2) chk("p4_muli_alu_func", int'(alu_func), 3);
`else
      if (k == 2) chk("p4_muli_alu_func", int'(alu_func), 0);
`endif
      if (k == 3) chk("p4_muli_pc", int'(pc), 1);
    end
    chk("p4_sb_drain", sbq.size(), 0);

    // Program 5: IN with the switch already pressed on entry.
    clear_rom();
    rom[0] = 16'hCC00;
    push_wr(1, 2, 3, 0, 0, 0);
    start();
    for (int k = 1; k <= 6; k++) begin
      cyc(k <= 4, 1'b0, 1'b0);
      if (k == 2) chk("p5_exec_in_wait", int'(in_wait), 0);
      if (k == 3) chk("p5_press_in_wait", int'(in_wait), 1);
      if (k == 4) chk("p5_rel_in_wait", int'(in_wait), 1);
      if (k == 6) begin
        chk("p5_after_pc", int'(pc), 1);
        chk("p5_after_in_wait", int'(in_wait), 0);
      end
    end
    chk("p5_sb_drain", sbq.size(), 0);

    // Program 6: reset lands in WAIT_PRESS while the switch is pressed.
    clear_rom();
    rom[1] = 16'hCC00;
    start();
    for (int k = 1; k <= 7; k++) begin
      cyc(k >= 6, 1'b0, k == 6);
      if (k == 5) begin
        chk("p6_wait_pc", int'(pc), 1);
        chk("p6_wait_in_wait", int'(in_wait), 1);
      end
      if (k == 6) chk("p6_rst_reg_we", int'(reg_we), 0);
      if (k == 7) begin
        chk("p6_post_pc",       int'(pc),       0);
        chk("p6_post_reg_we",   int'(reg_we),   0);
        chk("p6_post_in_wait",  int'(in_wait),  0);
        chk("p6_post_alu_func", int'(alu_func), 0);
        chk("p6_post_b_sel",    int'(b_sel),    0);
        chk("p6_post_rd",       int'(rd_addr),  0);
        chk("p6_post_rs",       int'(rs_addr),  0);
        chk("p6_post_imm",      int'(imm),      0);
      end
    end
    chk("p6_sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_seq.md
# prog_seq

Instruction decoder and sequencer for picoMIPS: the control-side counterpart that drives the ALU's function code and operand selects. It fetches 16-bit instructions from a synchronous program ROM, decodes them into ALU function, operand-B source, register addresses and write enable, and advances or branches the PC. It also sequences the press/release handshake for switch input. It sits between program ROM, register file, ALU and the board switches.

## Interface
- `Psize`, 6: PC / ROM address width
- `Isize`, 16: instruction width
- `n`, 8: datapath width (immediate width)
- `clk` input 1: clock, rising edge
- `reset` input 1: synchronous, active-high
- `instr` input Isize: ROM data, valid the cycle after `pc` is presented
- `zero` input 1: ALU result == 0 (ALU result is valid while `alu_func`=RA)
- `sw_valid` input 1: debounced input-strobe switch, level
- `pc` output Psize: ROM address
- `alu_func` output 2: ALU function code (RA/RB/RADD/RMUL)
- `b_sel` output 2: operand-B source: 0 = reg rs, 1 = immediate, 2 = switches
- `imm` output n: immediate field `instr[7:0]`
- `rd_addr` output 3: destination / operand-A register
- `rs_addr` output 3: source register
- `reg_we` output 1: register-file write strobe
- `in_wait` output 1: high while waiting on the switch handshake

## Operation
- Encoding: op `[15:13]`, rd `[12:10]`, rs `[9:7]`, imm `[7:0]`. rs and imm overlap in bit 7; each op uses only one of them.
- Ops:
  - NOP 000: no write
  - ADD 001: rd = rd + rs (RADD, b_sel 0)
  - ADDI 010: rd = rd + imm (RADD, b_sel 1)
  - MUL 011: rd = rd × rs (RMUL, b_sel 0)
  - MULI 100: rd = rd × imm (RMUL, b_sel 1)
  - MOV 101: rd = rs (RB, b_sel 0)
  - IN 110: rd = switches (RB, b_sel 2)
  - BZ 111: if rd == 0 then pc = pc + sext(imm) else pc + 1 (RA, no write)
- FSM states: FETCH, EXEC, WAIT_PRESS, WAIT_REL.
  - FETCH: present `pc`; `reg_we`=0; go to EXEC.
  - EXEC: decode `instr` combinationally.
    - Non-IN ops: `reg_we`=1 for writing ops; pc updates at clock edge; go to FETCH.
    - IN: go to WAIT_PRESS; no write in EXEC.
  - WAIT_PRESS: `in_wait`=1. While `sw_valid`=1: `reg_we`=1 for exactly that cycle, then go to WAIT_REL.
  - WAIT_REL: `in_wait`=1, `reg_we`=0. When `sw_valid`=0: pc+1, go to FETCH.
- Decode outputs hold the current instruction's values in all states after FETCH. `reg_we` is the only strobe.
- Arithmetic:
  - pc is modulo 2^Psize and wraps from 63 to 0.
  - Branch offset is `imm` sign-extended or truncated to Psize bits.
  - BZ with imm=0 is a self-loop (halt idiom).

## Timing
- Reset values: pc=0, state FETCH, reg_we=0, alu_func=RA, b_sel=0, rd_addr=0, rs_addr=0, imm=0, in_wait=0.
- Reset wins over every state, including mid-EXEC and mid-handshake: no write occurs on the reset cycle.
- Non-IN instruction: 2 cycles (FETCH + EXEC).
- IN instruction: at least 4 cycles (FETCH, EXEC, WAIT_PRESS, WAIT_REL).
- `sw_valid` already high on entry to WAIT_PRESS: write occurs in the first WAIT_PRESS cycle.
- `sw_valid` is ignored outside the wait states.
- BZ samples `zero` in EXEC only.

## Configuration
- `PICOMIPS_MUL_EN` defined: MUL and MULI decode as above.
- Undefined: MUL and MULI decode as NOP (reg_we=0, alu_func=RA, pc+1) so the multiplier can be dropped.

## Structure
- `picomips_pkg` holds:
  - ALU func constants: RA=00, RB=01, RADD=10, RMUL=11
  - opcode enum
  - `b_sel` enum
  - FSM state enum
- One sub-module, `pc_reg`: holds the PC register with sync reset, inc, and branch-load inputs.
- Decode and FSM stay in `prog_seq`.

## Test plan
- Reset then run ROM[0]=ADDI r1,5 (0x4405) → cycle 2 EXEC: alu_func=10, b_sel=1, imm=05, rd=1, reg_we=1 for one cycle; pc goes 0→1.
- ADD r2,r1 (0x2880) → alu_func=10, b_sel=0, rd=2, rs=1, reg_we=1; 2 cycles per instruction.
- IN r3 (0xCC00), `sw_valid` low 5 cycles, high 3, low → `in_wait` high throughout; exactly one `reg_we` pulse (first high cycle); pc advances only after release.
- BZ r0,-2 at pc=4 (0xE0FE):
  - zero=1 → pc=2
  - zero=0 → pc=5
  - at pc=0 with offset −1 → pc=63 (wrap)
- MULI r1,0x40 (0x8440):
  - with `PICOMIPS_MUL_EN` → alu_func=11, reg_we=1
  - without → reg_we=0, pc+1
- Assert reset during WAIT_PRESS with `sw_valid`=1 → no `reg_we`; next cycle pc=0, state FETCH, all outputs at reset values.
